// File: rtl/scope_pkg.sv
// Shared types, XADC auxiliary channel addresses and the sample-to-row scaling
// used by the scope capture engine.
package scope_pkg;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_SINGLE = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // XADC_Ports: DRP addresses of the auxiliary inputs wired to XA1..XA4
  typedef enum logic [6:0] {
    XA1 = 7'h16,
    XA2 = 7'h1E,
    XA3 = 7'h17,
    XA4 = 7'h1F
  } xadc_port_e;

  localparam logic [6:0] CH_PORT [4] = '{XA1, XA2, XA3, XA4};

  // Row 0 is the top of the screen, so larger samples map to smaller rows.
  function automatic logic [31:0] scale_y(input logic [31:0] data,
                                          input int screen_h,
                                          input int data_w);
    logic [63:0] prod;
    prod = 64'(data) * 64'(screen_h - 1);
    return 32'(screen_h - 1) - 32'(prod >> data_w);
  endfunction

endpackage

// File: rtl/scope_sample_ram.sv
// One channel of frame storage: simple dual-port RAM with a registered read
// whose output register clears on srst.
module scope_sample_ram #(
  parameter  int DEPTH = 640,
  parameter  int W     = 9,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scope_capture.sv
// Multi-channel XADC oscilloscope capture: round-robin sequencing, decimation,
// scaling and triggered frame capture. Define SCOPE_PRETRIG_EN for pre-trigger history.
module scope_capture
  import scope_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int DEPTH    = 640,
  parameter  int SCREEN_H = 480,
  parameter  int DATA_W   = 16,
  localparam int YW       = $clog2(SCREEN_H),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  output logic [6:0]        adc_port,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [15:0]       decim,
  input  logic              arm,
  input  logic              stop,
  input  logic [1:0]        rd_ch,
  input  logic [AW-1:0]     rd_addr,
  output logic [YW-1:0]     rd_data,
  output logic [1:0]        state_o,
  output logic              frame_done
);

  localparam int CNT_W = AW + 1;
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
`ifdef SCOPE_PRETRIG_EN
  localparam int FRAME_SETS = DEPTH / 2;
  localparam logic [AW:0] BACK = (AW+1)'(DEPTH - DEPTH / 2);
`else
  localparam int FRAME_SETS = DEPTH;
`endif

  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] samp_q [NUM_CH];
  logic [DATA_W-1:0] samp_d [NUM_CH];
  logic [DATA_W-1:0] cur [NUM_CH];
  logic [15:0]       dcnt_q, dcnt_d, dmax;
  logic              set_done, keep;

  logic              s1_valid_q, s1_valid_d;
  logic [YW-1:0]     s1_y_q [NUM_CH];
  logic [YW-1:0]     s1_y_d [NUM_CH];
  logic [DATA_W-1:0] s1_ch0_q, s1_ch0_d, prev_q, prev_d;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, start_q, start_d, wr_addr, raddr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_done_q, frame_done_d, wr_en, trig;
  logic [AW:0]       rd_sum;
  logic [1:0]        rd_ch_q;
  logic [YW-1:0]     ram_rdata [NUM_CH];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign adc_port = CH_PORT[idx_q];

  // Sequencer and decimation: a set is complete on the last channel's valid.
  always_comb begin
    idx_d    = idx_q;
    samp_d   = samp_q;
    dcnt_d   = dcnt_q;
    keep     = 1'b0;
    set_done = adc_valid && (idx_q == 2'(NUM_CH - 1));
    dmax     = (decim == 16'd0) ? 16'd0 : decim - 16'd1;
    for (int c = 0; c < NUM_CH; c++) begin
      cur[c] = (idx_q == 2'(c)) ? adc_data : samp_q[c];
      if (adc_valid && (idx_q == 2'(c))) begin
        samp_d[c] = adc_data;
      end
    end
    if (adc_valid) begin
      idx_d = (idx_q == 2'(NUM_CH - 1)) ? 2'd0 : idx_q + 2'd1;
    end
    if (set_done) begin
      if (dcnt_q >= dmax) begin
        keep   = 1'b1;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 16'd1;
      end
    end
  end

  // Scale stage: registers the multiplied rows of each kept set.
  always_comb begin
    s1_valid_d = keep;
    s1_ch0_d   = keep ? cur[0] : s1_ch0_q;
    prev_d     = s1_valid_q ? s1_ch0_q : prev_q;
    for (int c = 0; c < NUM_CH; c++) begin
      s1_y_d[c] = keep ? YW'(scale_y(32'(cur[c]), SCREEN_H, DATA_W)) : s1_y_q[c];
    end
  end

`ifdef SCOPE_PRETRIG_EN
  logic [AW:0] pre_start;
  always_comb begin
    pre_start = {1'b0, wr_ptr_q} + BACK;
    if (pre_start >= DEPTH_W) begin
      pre_start = pre_start - DEPTH_W;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    wr_ptr_d     = wr_ptr_q;
    start_d      = start_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q;
    trig = s1_valid_q && (prev_q < trig_level) && (s1_ch0_q >= trig_level);
    unique case (state_q)
      ST_ARMED: begin
`ifdef SCOPE_PRETRIG_EN
        if (s1_valid_q) begin
          wr_en    = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          if (trig || (mode_q == MODE_FREE)) begin
            start_d = pre_start[AW-1:0];
            cnt_d   = CNT_W'(1);
            state_d = ST_CAPTURE;
          end
        end
`else
        if (s1_valid_q && (trig || (mode_q == MODE_FREE))) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_ptr_d = ptr_inc('0);
          start_d  = '0;
          cnt_d    = CNT_W'(1);
          state_d  = ST_CAPTURE;
        end
`endif
      end
      ST_CAPTURE: begin
        if (s1_valid_q) begin
          wr_en    = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(FRAME_SETS)) begin
            state_d      = ST_HOLD;
            frame_done_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (mode_q != MODE_SINGLE) begin
          state_d = ST_ARMED;
        end
      end
      default: ;
    endcase
    // arm restarts from any state and discards the partial frame; stop dominates.
    if (stop || arm) begin
      wr_en        = 1'b0;
      wr_ptr_d     = wr_ptr_q;
      start_d      = start_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      if (stop) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_ARMED;
        mode_d  = (mode == 2'd0) ? MODE_FREE : (mode == 2'd1) ? MODE_NORMAL : MODE_SINGLE;
      end
    end
  end

  always_comb begin
    rd_sum = {1'b0, start_q} + {1'b0, rd_addr};
    if (rd_sum >= DEPTH_W) begin
      rd_sum = rd_sum - DEPTH_W;
    end
    raddr = rd_sum[AW-1:0];
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch_q == 2'(c)) begin
        rd_data = ram_rdata[c];
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      idx_q        <= '0;
      samp_q       <= '{default: '0};
      dcnt_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_y_q       <= '{default: '0};
      s1_ch0_q     <= '0;
      prev_q       <= '0;
      state_q      <= ST_IDLE;
      mode_q       <= MODE_FREE;
      wr_ptr_q     <= '0;
      start_q      <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      rd_ch_q      <= '0;
    end else begin
      idx_q        <= idx_d;
      samp_q       <= samp_d;
      dcnt_q       <= dcnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_y_q       <= s1_y_d;
      s1_ch0_q     <= s1_ch0_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      wr_ptr_q     <= wr_ptr_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      rd_ch_q      <= rd_ch;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    scope_sample_ram #(
      .DEPTH (DEPTH),
      .W     (YW)
    ) u_ram (
      .clk   (clk_100MHz),
      .srst  (rst),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (s1_y_q[gi]),
      .raddr (raddr),
      .rdata (ram_rdata[gi])
    );
  end

  assign state_o    = state_q;
  assign frame_done = frame_done_q;

endmodule
